// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl - Moore control FSM for the multi-cycle CPU.
//
// Sequences PC, IR, ALU, data memory and register file through the
// IF / ID / EXE / MEM / WB phases.  Only the phase register is clocked.
// Every control output is decoded combinationally from that register and
// the IR opcode, so the outputs are settled well before the register file
// samples on the falling edge.
//
// Ports
//   CLK        system clock, state advances on posedge
//   RST        asynchronous, active-low reset (state -> IF)
//   opcode     IR[31:26]
//   zero/sign  ALU flags: result == 0, result[31]
//   state      current state encoding (debug)
//   PCWre      PC loads on next posedge
//   PCSrc      00 pc+4, 01 branch target, 10 rs, 11 jump target
//   IRWre      IR loads on next posedge
//   InsMemRW   instruction memory read
//   ExtSel     1 sign-extend imm, 0 zero-extend
//   ALUSrcA    1 = shamt (unused by this instruction subset, held 0)
//   ALUSrcB    1 = extended imm, 0 = rt
//   ALUOp      000 add, 001 sub, 010 slt, 011 or, 100 and
//   mRD/mWR    data memory read / write
//   DBDataSrc  1 = memory data onto DB, 0 = ALU result
//   RegWre     register file write enable
//   RegDst     00 $31, 01 rt, 10 rd
//   WrRegDSrc  1 = DB, 0 = pc+4
//   illegal_op sticky unknown-opcode flag (only with CTRL_ILLEGAL_OP_EN)
//
// Build option CTRL_ILLEGAL_OP_EN: an unknown opcode in ID raises the
// sticky illegal_op output and parks the FSM in ID with every strobe low
// until RST.  Without it an unknown opcode executes as a NOP.
module multi_cycle_ctrl #(
  parameter int OP_W = 6,
  parameter int ST_W = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            sign,
  output logic [ST_W-1:0] state,
  output logic            PCWre,
  output logic [1:0]      PCSrc,
  output logic            IRWre,
  output logic            InsMemRW,
  output logic            ExtSel,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic            mRD,
  output logic            mWR,
  output logic            DBDataSrc,
  output logic            RegWre,
  output logic [1:0]      RegDst,
`ifdef CTRL_ILLEGAL_OP_EN
  output logic            illegal_op,
`endif
  output logic            WrRegDSrc
);

  typedef enum logic [ST_W-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b100111;
  localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
  localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OP_W-1:0] OP_J     = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  state_t curState;

  // Opcode classes
  logic isRAlu, isIAlu, isAlu, isBr, isLs, isJmp, isHalt, opKnown;
  logic brTaken;
  logic idLive;

  assign isRAlu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_SLT);
  assign isIAlu  = (opcode == OP_ADDIU) || (opcode == OP_ANDI) ||
                   (opcode == OP_ORI)   || (opcode == OP_SLTI);
  assign isAlu   = isRAlu || isIAlu;
  assign isBr    = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BLTZ);
  assign isLs    = (opcode == OP_SW) || (opcode == OP_LW);
  assign isJmp   = (opcode == OP_J) || (opcode == OP_JR) || (opcode == OP_JAL);
  assign isHalt  = (opcode == OP_HALT);
  assign opKnown = isAlu || isBr || isLs || isJmp || isHalt;

  assign brTaken = ((opcode == OP_BEQ)  &&  zero) ||
                   ((opcode == OP_BNE)  && !zero) ||
                   ((opcode == OP_BLTZ) &&  sign);

  // Once an illegal opcode has been latched, ID decodes nothing at all,
  // whatever the IR now holds.
`ifdef CTRL_ILLEGAL_OP_EN
  assign idLive = !illegal_op;
`else
  assign idLive = 1'b1;
`endif

  assign state = curState;

  // ALU operation for the arithmetic/logic instructions; loads and
  // stores fall through to add for address generation.
  function automatic logic [2:0] aluOpOf(input logic [OP_W-1:0] op);
    logic [2:0] r;
    r = 3'b000;
    if ((op == OP_SUB))                        r = 3'b001;
    else if ((op == OP_SLT) || (op == OP_SLTI)) r = 3'b010;
    else if (op == OP_ORI)                     r = 3'b011;
    else if ((op == OP_AND) || (op == OP_ANDI)) r = 3'b100;
    return r;
  endfunction

  // ---- state register ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      curState <= S_IF;
`ifdef CTRL_ILLEGAL_OP_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      case (curState)
        S_IF: curState <= S_ID;
        S_ID: begin
`ifdef CTRL_ILLEGAL_OP_EN
          if (illegal_op)   curState <= S_ID;
          else
`endif
          if (isJmp)        curState <= S_IF;
          else if (isHalt)  curState <= S_ID;
          else if (isBr)    curState <= S_EXE_BR;
          else if (isLs)    curState <= S_EXE_LS;
          else if (isAlu)   curState <= S_EXE_AL;
          else begin
`ifdef CTRL_ILLEGAL_OP_EN
            curState   <= S_ID;
            illegal_op <= 1'b1;
`else
            curState <= S_IF;
`endif
          end
        end
        S_EXE_AL: curState <= S_WB_AL;
        S_EXE_LS: curState <= S_MEM;
        S_MEM:    curState <= (opcode == OP_LW) ? S_WB_LD : S_IF;
        default:  curState <= S_IF;
      endcase
    end
  end

  // ---- output decode from state and opcode ----
  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    case (curState)
      S_IF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
      end
      S_ID: begin
        if (idLive) begin
          if ((opcode == OP_J) || (opcode == OP_JAL)) begin
            PCWre = 1'b1;
            PCSrc = 2'b11;
          end else if (opcode == OP_JR) begin
            PCWre = 1'b1;
            PCSrc = 2'b10;
          end
`ifndef CTRL_ILLEGAL_OP_EN
          else if (!opKnown) begin
            PCWre = 1'b1;   // NOP: step to pc+4
          end
`endif
          // jal links pc+4 into $31 on the ID falling edge
          if (opcode == OP_JAL) begin
            RegWre    = 1'b1;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
          end
        end
      end
      S_EXE_BR: begin
        // bltz compares rs against $0 through the rt path
        ALUOp   = 3'b001;
        ALUSrcB = 1'b0;
        PCWre   = 1'b1;
        PCSrc   = brTaken ? 2'b01 : 2'b00;
      end
      S_EXE_LS: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        ALUOp   = 3'b000;
      end
      S_MEM: begin
        // address generation held so the memory sees a stable address
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        ALUOp   = 3'b000;
        if (opcode == OP_LW) begin
          mRD = 1'b1;
        end else begin
          mWR   = 1'b1;
          PCWre = 1'b1;
          PCSrc = 2'b00;
        end
      end
      S_WB_LD: begin
        mRD       = 1'b1;
        DBDataSrc = 1'b1;
        RegWre    = 1'b1;
        RegDst    = 2'b01;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
        PCSrc     = 2'b00;
      end
      S_EXE_AL, S_WB_AL: begin
        // ALU controls identical in both states so the result stays put
        ALUOp   = aluOpOf(opcode);
        ALUSrcB = isIAlu;
        RegDst  = isIAlu ? 2'b01 : 2'b10;
        ExtSel  = (opcode == OP_ADDIU) || (opcode == OP_SLTI);
        if (curState == S_WB_AL) begin
          RegWre    = 1'b1;
          DBDataSrc = 1'b0;
          WrRegDSrc = 1'b1;
          PCWre     = 1'b1;
          PCSrc     = 2'b00;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] opcode;
  logic       zero, sign;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;
  logic       mRD, mWR, DBDataSrc, RegWre, WrRegDSrc;
`ifdef CTRL_ILLEGAL_OP_EN
  logic       illegal_op;
`endif

  multi_cycle_ctrl dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .sign(sign),
    .state(state), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre),
    .InsMemRW(InsMemRW), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .DBDataSrc(DBDataSrc), .RegWre(RegWre), .RegDst(RegDst),
`ifdef CTRL_ILLEGAL_OP_EN
    .illegal_op(illegal_op),
`endif
    .WrRegDSrc(WrRegDSrc)
  );

  always #5 CLK = ~CLK;

  // Control bundle field order:
  // PCWre PCSrc IRWre InsMemRW ExtSel ALUSrcA ALUSrcB ALUOp mRD mWR DBDataSrc RegWre RegDst WrRegDSrc
  logic [17:0] actCtrl;
  assign actCtrl = {PCWre, PCSrc, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB,
                    ALUOp, mRD, mWR, DBDataSrc, RegWre, RegDst, WrRegDSrc};

  localparam logic [17:0] C_IF   = 18'b0_00_1_1_0_0_0_000_0_0_0_0_00_0;
  localparam logic [17:0] C_NONE = 18'b0;

  typedef struct packed {
    logic [5:0]  op;
    logic        z;
    logic        s;
    logic [2:0]  st;
    logic [17:0] ctrl;
  } vec_t;

  typedef struct packed {
    logic [2:0]  st;
    logic [17:0] ctrl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int nVec = 0;
  int nMis = 0;

  function automatic vec_t V(logic [5:0] op, logic z, logic s,
                             logic [2:0] st, logic [17:0] c);
    return {op, z, s, st, c};
  endfunction

  task automatic drive(input logic [5:0] op, input logic z, input logic s);
    opcode = op;
    zero   = z;
    sign   = s;
  endtask

  // Push expectation, let combinational outputs settle, pop and compare.
  task automatic check(input string nm, input logic [2:0] st, input logic [17:0] c);
    exp_t e;
    sb.push_back({st, c});
    #1;
    if (sb.size() == 0) begin
      nMis++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      nVec++;
      if (state !== e.st || actCtrl !== e.ctrl) begin
        nMis++;
        $display("FAIL %s: got state=%b ctrl=%b, want state=%b ctrl=%b",
                 nm, state, actCtrl, e.st, e.ctrl);
      end
    end
  endtask

  // Apply one cycle's inputs, compare, then advance to the next falling edge.
  task automatic applyVec(input string nm, input vec_t v);
    drive(v.op, v.z, v.s);
    check(nm, v.st, v.ctrl);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", nVec);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- vector table ----
    // add
    vecs.push_back(V(6'b000000, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b000000, 0, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b000000, 0, 0, 3'b110, 18'b0_00_0_0_0_0_0_000_0_0_0_0_10_0));
    vecs.push_back(V(6'b000000, 0, 0, 3'b111, 18'b1_00_0_0_0_0_0_000_0_0_0_1_10_1));
    // sub
    vecs.push_back(V(6'b000001, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b000001, 0, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b000001, 0, 0, 3'b110, 18'b0_00_0_0_0_0_0_001_0_0_0_0_10_0));
    vecs.push_back(V(6'b000001, 0, 0, 3'b111, 18'b1_00_0_0_0_0_0_001_0_0_0_1_10_1));
    // addiu (sign-extended immediate)
    vecs.push_back(V(6'b000010, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b000010, 0, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b000010, 0, 0, 3'b110, 18'b0_00_0_0_1_0_1_000_0_0_0_0_01_0));
    vecs.push_back(V(6'b000010, 0, 0, 3'b111, 18'b1_00_0_0_1_0_1_000_0_0_0_1_01_1));
    // ori (zero-extended immediate)
    vecs.push_back(V(6'b010010, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b010010, 0, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b010010, 0, 0, 3'b110, 18'b0_00_0_0_0_0_1_011_0_0_0_0_01_0));
    vecs.push_back(V(6'b010010, 0, 0, 3'b111, 18'b1_00_0_0_0_0_1_011_0_0_0_1_01_1));
    // andi
    vecs.push_back(V(6'b010001, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b010001, 0, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b010001, 0, 0, 3'b110, 18'b0_00_0_0_0_0_1_100_0_0_0_0_01_0));
    vecs.push_back(V(6'b010001, 0, 0, 3'b111, 18'b1_00_0_0_0_0_1_100_0_0_0_1_01_1));
    // slt
    vecs.push_back(V(6'b100110, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b100110, 0, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b100110, 0, 0, 3'b110, 18'b0_00_0_0_0_0_0_010_0_0_0_0_10_0));
    vecs.push_back(V(6'b100110, 0, 0, 3'b111, 18'b1_00_0_0_0_0_0_010_0_0_0_1_10_1));
    // lw
    vecs.push_back(V(6'b110001, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b110001, 0, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b110001, 0, 0, 3'b010, 18'b0_00_0_0_1_0_1_000_0_0_0_0_00_0));
    vecs.push_back(V(6'b110001, 0, 0, 3'b011, 18'b0_00_0_0_1_0_1_000_1_0_0_0_00_0));
    vecs.push_back(V(6'b110001, 0, 0, 3'b100, 18'b1_00_0_0_0_0_0_000_1_0_1_1_01_1));
    // sw
    vecs.push_back(V(6'b110000, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b110000, 0, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b110000, 0, 0, 3'b010, 18'b0_00_0_0_1_0_1_000_0_0_0_0_00_0));
    vecs.push_back(V(6'b110000, 0, 0, 3'b011, 18'b1_00_0_0_1_0_1_000_0_1_0_0_00_0));
    // beq taken / not taken
    vecs.push_back(V(6'b110100, 1, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b110100, 1, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b110100, 1, 0, 3'b101, 18'b1_01_0_0_0_0_0_001_0_0_0_0_00_0));
    vecs.push_back(V(6'b110100, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b110100, 0, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b110100, 0, 0, 3'b101, 18'b1_00_0_0_0_0_0_001_0_0_0_0_00_0));
    // bne taken / not taken
    vecs.push_back(V(6'b110101, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b110101, 0, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b110101, 0, 0, 3'b101, 18'b1_01_0_0_0_0_0_001_0_0_0_0_00_0));
    vecs.push_back(V(6'b110101, 1, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b110101, 1, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b110101, 1, 0, 3'b101, 18'b1_00_0_0_0_0_0_001_0_0_0_0_00_0));
    // bltz taken (sign) / not taken (zero alone does not branch)
    vecs.push_back(V(6'b110110, 0, 1, 3'b000, C_IF));
    vecs.push_back(V(6'b110110, 0, 1, 3'b001, C_NONE));
    vecs.push_back(V(6'b110110, 0, 1, 3'b101, 18'b1_01_0_0_0_0_0_001_0_0_0_0_00_0));
    vecs.push_back(V(6'b110110, 1, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b110110, 1, 0, 3'b001, C_NONE));
    vecs.push_back(V(6'b110110, 1, 0, 3'b101, 18'b1_00_0_0_0_0_0_001_0_0_0_0_00_0));
    // j, jr, jal
    vecs.push_back(V(6'b111000, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b111000, 0, 0, 3'b001, 18'b1_11_0_0_0_0_0_000_0_0_0_0_00_0));
    vecs.push_back(V(6'b111001, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b111001, 0, 0, 3'b001, 18'b1_10_0_0_0_0_0_000_0_0_0_0_00_0));
    vecs.push_back(V(6'b111010, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b111010, 0, 0, 3'b001, 18'b1_11_0_0_0_0_0_000_0_0_0_1_00_0));
`ifndef CTRL_ILLEGAL_OP_EN
    // unknown opcode executes as NOP
    vecs.push_back(V(6'b101010, 0, 0, 3'b000, C_IF));
    vecs.push_back(V(6'b101010, 0, 0, 3'b001, 18'b1_00_0_0_0_0_0_000_0_0_0_0_00_0));
`endif

    // ---- reset state ----
    RST = 1'b0;
    drive(6'b000000, 1'b0, 1'b0);
    #1;
    check("reset", 3'b000, C_IF);
    @(negedge CLK);
    check("reset_hold", 3'b000, C_IF);
    RST = 1'b1;

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++)
      applyVec($sformatf("vec%0d_op%b", i, vecs[i].op), vecs[i]);

    // ---- asynchronous reset in the middle of EXE_AL ----
    applyVec("arst_if",  V(6'b000000, 0, 0, 3'b000, C_IF));
    applyVec("arst_id",  V(6'b000000, 0, 0, 3'b001, C_NONE));
    drive(6'b000000, 1'b0, 1'b0);
    check("arst_exe", 3'b110, 18'b0_00_0_0_0_0_0_000_0_0_0_0_10_0);
    RST = 1'b0;
    check("arst_immediate", 3'b000, C_IF);
    @(negedge CLK);
    check("arst_held", 3'b000, C_IF);
    RST = 1'b1;
    applyVec("post_arst_if",  V(6'b000000, 0, 0, 3'b000, C_IF));
    applyVec("post_arst_id",  V(6'b000000, 0, 0, 3'b001, C_NONE));
    applyVec("post_arst_exe", V(6'b000000, 0, 0, 3'b110, 18'b0_00_0_0_0_0_0_000_0_0_0_0_10_0));
    applyVec("post_arst_wb",  V(6'b000000, 0, 0, 3'b111, 18'b1_00_0_0_0_0_0_000_0_0_0_1_10_1));

    // ---- halt parks in ID with PC frozen ----
    applyVec("halt_if", V(6'b111111, 0, 0, 3'b000, C_IF));
    for (int k = 0; k < 11; k++)
      applyVec($sformatf("halt_id%0d", k), V(6'b111111, 0, 0, 3'b001, C_NONE));
    RST = 1'b0;
    check("halt_reset", 3'b000, C_IF);
    @(negedge CLK);
    RST = 1'b1;

`ifdef CTRL_ILLEGAL_OP_EN
    // ---- illegal opcode: sticky flag, stuck in ID ----
    applyVec("ill_if", V(6'b101010, 0, 0, 3'b000, C_IF));
    nVec++;
    if (illegal_op !== 1'b0) begin
      nMis++;
      $display("FAIL ill_flag_clear: got %b, want 0", illegal_op);
    end
    applyVec("ill_id0", V(6'b101010, 0, 0, 3'b001, C_NONE));
    applyVec("ill_id1", V(6'b101010, 0, 0, 3'b001, C_NONE));
    nVec++;
    if (illegal_op !== 1'b1) begin
      nMis++;
      $display("FAIL ill_flag_set: got %b, want 1", illegal_op);
    end
    // a jump in the IR must not release the parked FSM
    applyVec("ill_id_j0", V(6'b111000, 0, 0, 3'b001, C_NONE));
    applyVec("ill_id_j1", V(6'b111000, 0, 0, 3'b001, C_NONE));
    RST = 1'b0;
    check("ill_reset", 3'b000, C_IF);
    nVec++;
    if (illegal_op !== 1'b0) begin
      nMis++;
      $display("FAIL ill_flag_reset: got %b, want 0", illegal_op);
    end
    @(negedge CLK);
    RST = 1'b1;
`endif

    if (sb.size() != 0) begin
      nMis++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Moore-style control FSM for the multi-cycle CPU. Sits directly upstream of the register file and drives its RegWre, RegDst and WrRegDSrc.
- Also sequences the PC, instruction register, ALU and data memory through the IF/ID/EXE/MEM/WB phases.
- Inputs are the IR opcode plus ALU zero/sign flags. All control outputs are decoded from the current state and opcode.

Parameters:
- OP_W, 6, opcode width
- ST_W, 3, state register width

Ports:
- CLK  in  1  system clock; state advances on posedge
- RST  in  1  reset, asynchronous, active-low
- opcode  in  6  IR[31:26]
- zero  in  1  ALU result == 0
- sign  in  1  ALU result[31]
- state  out  3  current state encoding (debug)
- PCWre  out  1  PC loads on next posedge
- PCSrc  out  2  00 pc+4, 01 pc+4+(sext(imm)<<2), 10 rs, 11 {pc[31:28],addr,2'b00}
- IRWre  out  1  IR loads on next posedge
- InsMemRW  out  1  1 = instruction memory read
- ExtSel  out  1  1 sign-extend imm, 0 zero-extend
- ALUSrcA  out  1  1 = shamt (unused by subset, held 0)
- ALUSrcB  out  1  1 = extended imm, 0 = rt
- ALUOp  out  3  000 add, 001 sub, 010 slt signed, 011 or, 100 and
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- DBDataSrc  out  1  1 = memory data onto DB, 0 = ALU result
- RegWre  out  1  register file write enable (regfile samples on negedge)
- RegDst  out  2  00 $31, 01 rt, 10 rd
- WrRegDSrc  out  1  1 = DB, 0 = pc+4

Behaviour:
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
- States: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- Transitions:
  - IF->ID, always.
  - ID: j/jal/jr -> IF; halt -> ID (hold until reset); beq/bne/bltz -> EXE_BR; sw/lw -> EXE_LS; ALU ops -> EXE_AL.
  - EXE_AL->WB_AL; WB_AL->IF; EXE_BR->IF; EXE_LS->MEM; MEM: sw -> IF, lw -> WB_LD; WB_LD->IF.
- Reset: state = IF. Reset is asynchronous and overrides any state, including mid-instruction.
- Strobes are 0 except in the states listed:
  - IF: IRWre=1, InsMemRW=1.
  - ID: j/jal: PCWre=1, PCSrc=11. jr: PCWre=1, PCSrc=10. jal additionally RegWre=1, RegDst=00, WrRegDSrc=0, so $31 = pc+4 is written on the ID negedge.
  - EXE_BR: ALUOp=001; PCWre=1.
    - PCSrc=01 if (beq & zero) | (bne & ~zero) | (bltz & sign), else 00.
    - bltz compares rs against $0 via ALUSrcB=0.
  - EXE_LS and MEM: ALUSrcB=1, ExtSel=1, ALUOp=000, held through MEM. MEM: lw -> mRD=1; sw -> mWR=1, PCWre=1, PCSrc=00.
  - WB_LD: mRD=1, DBDataSrc=1, RegWre=1, RegDst=01, WrRegDSrc=1, PCWre=1, PCSrc=00.
  - EXE_AL and WB_AL: ALU controls held constant across both states.
    - R-type: RegDst=10, ALUSrcB=0.
    - I-type: RegDst=01, ALUSrcB=1; ExtSel=1 for addiu/slti, 0 for andi/ori.
    - WB_AL also drives RegWre=1, DBDataSrc=0, WrRegDSrc=1, PCWre=1, PCSrc=00.
- Timing: outputs are purely combinational from registered state and opcode, so they are glitch-free by the regfile negedge.
- Latency in cycles: j/jr/jal 2, branch 3, sw 4, ALU 4, lw 5.
- ALUOp by instruction: add/addiu 000, sub 001, slt/slti 010, or/ori 011, and/andi 100.
- Unknown opcode in ID: NOP, i.e. PCWre=1, PCSrc=00, next state IF, no writes.

Optional Feature:
- Macro: CTRL_ILLEGAL_OP_EN.
- Defined: adds output port illegal_op (1 bit).
  - Unknown opcode in ID sets illegal_op sticky, and the FSM holds in ID with all strobes 0.
  - illegal_op is cleared only by RST.
- Undefined: no port; unknown opcode behaves as NOP as above.

Test Plan:
- RST low mid-EXE_AL (state=110) -> state=000 immediately, RegWre=0, PCWre=0; release -> IF->ID on next posedges.
- opcode=000000 (add) -> state sequence 000,001,110,111,000. In WB_AL: RegWre=1, RegDst=10, WrRegDSrc=1, ALUOp=000, PCWre=1, PCSrc=00.
- opcode=110001 (lw) -> states 000,001,010,011,100,000. mRD=1 in MEM and WB_LD, RegDst=01, DBDataSrc=1; sw (110000) -> ends at MEM with mWR=1, no RegWre.
- opcode=110100 (beq) with zero=1 -> EXE_BR PCSrc=01; zero=0 -> PCSrc=00. bltz with sign=1 -> 01.
- opcode=111010 (jal) -> in ID: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; next state IF.
- opcode=111111 (halt) -> state stays 001 for 10 cycles, PCWre=0. opcode=101010 -> NOP (no macro) or illegal_op=1 and stuck in ID (CTRL_ILLEGAL_OP_EN).
